// File: rtl/riscv_system_onchip_memory_dp.sv
// True dual-port on-chip RAM with byte enables, per-port clock enables and a
// 1- or 2-cycle registered read path; same-address dual writes merge per byte.
module riscv_system_onchip_memory_dp #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 13,
  parameter int unsigned READ_LATENCY = 1,
  parameter string       INIT_FILE    = "",
  parameter int unsigned PRIO_A       = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    reset_req,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH/8-1:0] byteenable,
  input  logic                    chipselect,
  input  logic                    write,
  input  logic                    clken,
  input  logic [DATA_WIDTH-1:0]   writedata,
  output logic [DATA_WIDTH-1:0]   readdata,
  output logic                    readdatavalid,
  input  logic [ADDR_WIDTH-1:0]   address2,
  input  logic [DATA_WIDTH/8-1:0] byteenable2,
  input  logic                    chipselect2,
  input  logic                    write2,
  input  logic                    clken2,
  input  logic [DATA_WIDTH-1:0]   writedata2,
  output logic [DATA_WIDTH-1:0]   readdata2,
  output logic                    readdatavalid2,
  output logic                    collision,
  input  logic                    collision_clr
);

  localparam int unsigned NB    = DATA_WIDTH / 8;
  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic en_a, en_b;
  logic rd_a, rd_b;
  logic wr_a, wr_b;
  logic same_wr;
  logic [DATA_WIDTH-1:0] word_a, word_b;

  // Write ports ordered low-then-high priority inside one always_ff.
  logic                  wr_lo, wr_hi;
  logic [ADDR_WIDTH-1:0] addr_lo, addr_hi;
  logic [NB-1:0]         be_lo, be_hi;
  logic [DATA_WIDTH-1:0] wd_lo, wd_hi;

  logic                  s1_valid_a_d, s1_valid_a_q, s1_valid_b_d, s1_valid_b_q;
  logic [DATA_WIDTH-1:0] s1_data_a_d, s1_data_a_q, s1_data_b_d, s1_data_b_q;
  logic                  rdv_a_d, rdv_a_q, rdv_b_d, rdv_b_q;
  logic [DATA_WIDTH-1:0] rdata_a_d, rdata_a_q, rdata_b_d, rdata_b_q;
  logic                  coll_d, coll_q;

  always_comb begin
    en_a    = clken & ~reset_req & ~reset;
    en_b    = clken2 & ~reset_req & ~reset;
    rd_a    = en_a & chipselect & ~write;
    rd_b    = en_b & chipselect2 & ~write2;
    wr_a    = en_a & chipselect & write;
    wr_b    = en_b & chipselect2 & write2;
    same_wr = wr_a & wr_b & (address == address2);
    word_a  = mem_q[address];
    word_b  = mem_q[address2];
  end

  always_comb begin
    if (PRIO_A != 0) begin
      wr_lo = wr_b;  addr_lo = address2; be_lo = byteenable2; wd_lo = writedata2;
      wr_hi = wr_a;  addr_hi = address;  be_hi = byteenable;  wd_hi = writedata;
    end else begin
      wr_lo = wr_a;  addr_lo = address;  be_lo = byteenable;  wd_lo = writedata;
      wr_hi = wr_b;  addr_hi = address2; be_hi = byteenable2; wd_hi = writedata2;
    end
  end

  // Later non-blocking write wins per lane, so the priority port is applied last.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NB; i++) begin
      if (wr_lo && be_lo[i]) mem_q[addr_lo][i*8 +: 8] <= wd_lo[i*8 +: 8];
      if (wr_hi && be_hi[i]) mem_q[addr_hi][i*8 +: 8] <= wd_hi[i*8 +: 8];
    end
  end

  always_comb begin
    s1_valid_a_d = s1_valid_a_q;
    s1_data_a_d  = s1_data_a_q;
    rdv_a_d      = rdv_a_q;
    rdata_a_d    = rdata_a_q;
    if (en_a) begin
      s1_valid_a_d = rd_a;
      if (rd_a) s1_data_a_d = word_a;
      if (READ_LATENCY == 2) begin
        rdv_a_d = s1_valid_a_q;
        if (s1_valid_a_q) rdata_a_d = s1_data_a_q;
      end else begin
        rdv_a_d = rd_a;
        if (rd_a) rdata_a_d = word_a;
      end
    end
  end

  always_comb begin
    s1_valid_b_d = s1_valid_b_q;
    s1_data_b_d  = s1_data_b_q;
    rdv_b_d      = rdv_b_q;
    rdata_b_d    = rdata_b_q;
    if (en_b) begin
      s1_valid_b_d = rd_b;
      if (rd_b) s1_data_b_d = word_b;
      if (READ_LATENCY == 2) begin
        rdv_b_d = s1_valid_b_q;
        if (s1_valid_b_q) rdata_b_d = s1_data_b_q;
      end else begin
        rdv_b_d = rd_b;
        if (rd_b) rdata_b_d = word_b;
      end
    end
  end

  always_comb begin
    coll_d = coll_q;
    if (collision_clr) coll_d = 1'b0;
    if (same_wr)       coll_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_a_q <= 1'b0;
      s1_data_a_q  <= '0;
      s1_valid_b_q <= 1'b0;
      s1_data_b_q  <= '0;
      rdv_a_q      <= 1'b0;
      rdata_a_q    <= '0;
      rdv_b_q      <= 1'b0;
      rdata_b_q    <= '0;
      coll_q       <= 1'b0;
    end else begin
      s1_valid_a_q <= s1_valid_a_d;
      s1_data_a_q  <= s1_data_a_d;
      s1_valid_b_q <= s1_valid_b_d;
      s1_data_b_q  <= s1_data_b_d;
      rdv_a_q      <= rdv_a_d;
      rdata_a_q    <= rdata_a_d;
      rdv_b_q      <= rdv_b_d;
      rdata_b_q    <= rdata_b_d;
      coll_q       <= coll_d;
    end
  end

  assign readdata       = rdata_a_q;
  assign readdatavalid  = rdv_a_q;
  assign readdata2      = rdata_b_q;
  assign readdatavalid2 = rdv_b_q;
  assign collision      = coll_q;

endmodule

// File: tb/tb_riscv_system_onchip_memory_dp.sv
// Bench: two instances (latency 1 / port-A priority, latency 2 / port-B priority)
// driven identically and compared every cycle against a queue-based memory model.
module tb_riscv_system_onchip_memory_dp;

  localparam int DW    = 32;
  localparam int AW    = 8;
  localparam int BE    = DW / 8;
  localparam int DEPTH = 2 ** AW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, reset_req, collision_clr;
  logic [AW-1:0] address, address2;
  logic [BE-1:0] byteenable, byteenable2;
  logic          chipselect, write, clken, chipselect2, write2, clken2;
  logic [DW-1:0] writedata, writedata2;

  logic [DW-1:0] rda [2];
  logic [DW-1:0] rdb [2];
  logic          rdv_a [2];
  logic          rdv_b [2];
  logic          coll [2];

  riscv_system_onchip_memory_dp #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1), .PRIO_A(1)
  ) dut0 (
    .clk(clk), .reset(reset), .reset_req(reset_req),
    .address(address), .byteenable(byteenable), .chipselect(chipselect),
    .write(write), .clken(clken), .writedata(writedata),
    .readdata(rda[0]), .readdatavalid(rdv_a[0]),
    .address2(address2), .byteenable2(byteenable2), .chipselect2(chipselect2),
    .write2(write2), .clken2(clken2), .writedata2(writedata2),
    .readdata2(rdb[0]), .readdatavalid2(rdv_b[0]),
    .collision(coll[0]), .collision_clr(collision_clr)
  );

  riscv_system_onchip_memory_dp #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(2), .PRIO_A(0)
  ) dut1 (
    .clk(clk), .reset(reset), .reset_req(reset_req),
    .address(address), .byteenable(byteenable), .chipselect(chipselect),
    .write(write), .clken(clken), .writedata(writedata),
    .readdata(rda[1]), .readdatavalid(rdv_a[1]),
    .address2(address2), .byteenable2(byteenable2), .chipselect2(chipselect2),
    .write2(write2), .clken2(clken2), .writedata2(writedata2),
    .readdata2(rdb[1]), .readdatavalid2(rdv_b[1]),
    .collision(coll[1]), .collision_clr(collision_clr)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] init_word(input int i);
    return 32'hC0DE0000 + DW'(i);
  endfunction

  // Reference model: memory image, read-result delay line per port, sticky flag.
  typedef struct packed {
    logic          v;
    logic [DW-1:0] d;
  } ent_t;

  logic [DW-1:0] mmem [2][DEPTH];
  ent_t          pq [2][2][$];
  logic          e_v [2][2];
  logic [DW-1:0] e_d [2][2];
  logic          e_c [2];

  task automatic model_step(input int d);
    int            lat;
    logic [AW-1:0] ad [2];
    logic [BE-1:0] be [2];
    logic [DW-1:0] wd [2];
    logic [DW-1:0] old [2];
    logic          en [2];
    logic          rd [2];
    logic          wr [2];
    logic [DW-1:0] w;
    ent_t          e;
    lat   = (d == 0) ? 1 : 2;
    ad[0] = address;    ad[1] = address2;
    be[0] = byteenable; be[1] = byteenable2;
    wd[0] = writedata;  wd[1] = writedata2;
    en[0] = clken && !reset_req;
    en[1] = clken2 && !reset_req;
    rd[0] = en[0] && chipselect && !write;
    rd[1] = en[1] && chipselect2 && !write2;
    wr[0] = en[0] && chipselect && write;
    wr[1] = en[1] && chipselect2 && write2;
    if (reset) begin
      for (int p = 0; p < 2; p++) begin
        pq[d][p].delete();
        e.v = 1'b0;
        e.d = '0;
        for (int k = 1; k < lat; k++) pq[d][p].push_back(e);
        e_v[d][p] = 1'b0;
        e_d[d][p] = '0;
      end
      e_c[d] = 1'b0;
      return;
    end
    for (int p = 0; p < 2; p++) old[p] = mmem[d][ad[p]];
    for (int p = 0; p < 2; p++) begin
      if (en[p]) begin
        e.v = rd[p];
        e.d = old[p];
        pq[d][p].push_back(e);
        e = pq[d][p].pop_front();
        e_v[d][p] = e.v;
        if (e.v) e_d[d][p] = e.d;
      end
    end
    if (wr[0] && wr[1] && ad[0] == ad[1]) begin
      w = mmem[d][ad[0]];
      for (int l = 0; l < BE; l++) begin
        if (be[0][l] && be[1][l]) w[l*8 +: 8] = (d == 0) ? wd[0][l*8 +: 8] : wd[1][l*8 +: 8];
        else if (be[0][l])        w[l*8 +: 8] = wd[0][l*8 +: 8];
        else if (be[1][l])        w[l*8 +: 8] = wd[1][l*8 +: 8];
      end
      mmem[d][ad[0]] = w;
      e_c[d] = 1'b1;
    end else begin
      for (int p = 0; p < 2; p++)
        if (wr[p])
          for (int l = 0; l < BE; l++)
            if (be[p][l]) mmem[d][ad[p]][l*8 +: 8] = wd[p][l*8 +: 8];
      if (collision_clr) e_c[d] = 1'b0;
    end
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("m%0d_rdv_a", d), DW'(rdv_a[d]), DW'(e_v[d][0]));
        chk($sformatf("m%0d_rdv_b", d), DW'(rdv_b[d]), DW'(e_v[d][1]));
        chk($sformatf("m%0d_rd_a", d), rda[d], e_d[d][0]);
        chk($sformatf("m%0d_rd_b", d), rdb[d], e_d[d][1]);
        chk($sformatf("m%0d_coll", d), DW'(coll[d]), DW'(e_c[d]));
      end
    end
  end

  task automatic idle();
    reset = 1'b0; reset_req = 1'b0; collision_clr = 1'b0;
    chipselect = 1'b0; write = 1'b0; clken = 1'b1;
    address = '0; byteenable = '0; writedata = '0;
    chipselect2 = 1'b0; write2 = 1'b0; clken2 = 1'b1;
    address2 = '0; byteenable2 = '0; writedata2 = '0;
  endtask

  task automatic nx();
    @(negedge clk);
    idle();
  endtask

  task automatic wr_a(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BE-1:0] b);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d; byteenable = b;
  endtask

  task automatic wr_b(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BE-1:0] b);
    chipselect2 = 1'b1; write2 = 1'b1; address2 = a; writedata2 = d; byteenable2 = b;
  endtask

  task automatic rd_a(input logic [AW-1:0] a);
    chipselect = 1'b1; write = 1'b0; address = a;
  endtask

  task automatic rd_b(input logic [AW-1:0] a);
    chipselect2 = 1'b1; write2 = 1'b0; address2 = a;
  endtask

  initial begin
    int            nxt;
    bit            prev_en;
    logic [DW-1:0] got [$];

    idle();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_rdv_a", DW'(rdv_a[d]), '0);
      chk("rst_rd_b", rdb[d], '0);
      chk("rst_coll", DW'(coll[d]), '0);
    end
    idle();

    for (int i = 0; i < DEPTH / 2; i++) begin
      nx();
      wr_a(AW'(2 * i), init_word(2 * i), '1);
      wr_b(AW'(2 * i + 1), init_word(2 * i + 1), '1);
    end

    // Write A, read B.
    nx(); wr_a(8'h10, 32'hDEADBEEF, 4'hF);
    nx(); rd_b(8'h10);
    nx();
    chk("wr_rd_v_l1", DW'(rdv_b[0]), 1);
    chk("wr_rd_d_l1", rdb[0], 32'hDEADBEEF);
    chk("wr_rd_v_l2_early", DW'(rdv_b[1]), 0);
    nx();
    chk("wr_rd_v_l2", DW'(rdv_b[1]), 1);
    chk("wr_rd_d_l2", rdb[1], 32'hDEADBEEF);
    chk("wr_rd_v_l1_once", DW'(rdv_b[0]), 0);

    // Same-address dual write with byte merge.
    wr_a(8'h20, 32'h11223344, 4'hF);
    nx(); wr_a(8'h20, 32'hAAAAAAAA, 4'h3); wr_b(8'h20, 32'hBBBBBBBB, 4'h6);
    nx();
    chk("coll_set0", DW'(coll[0]), 1);
    chk("coll_set1", DW'(coll[1]), 1);
    rd_a(8'h20);
    nx();
    chk("merge_prio_a", rda[0], 32'h11BBAAAA);
    nx();
    chk("merge_prio_b", rda[1], 32'h11BBBBAA);

    // Clear concurrent with a new collision keeps the flag; clear alone drops it.
    collision_clr = 1'b1; wr_a(8'h40, 32'h1, 4'h1); wr_b(8'h40, 32'h2, 4'h2);
    nx();
    chk("coll_set_wins", DW'(coll[0]), 1);
    collision_clr = 1'b1;
    nx();
    chk("coll_clr", DW'(coll[0]), 0);

    // Mixed-port read-during-write returns old data.
    wr_a(8'h30, 32'h1, 4'hF);
    nx(); wr_a(8'h30, 32'h2, 4'hF); rd_b(8'h30);
    nx();
    chk("rdw_old", rdb[0], 32'h1);
    rd_b(8'h30);
    nx();
    chk("rdw_new", rdb[0], 32'h2);

    // Read then reset: in-flight read is dropped, memory survives.
    rd_a(8'h10);
    nx(); reset = 1'b1;
    nx();
    for (int d = 0; d < 2; d++) begin
      chk("rst_flush_v", DW'(rdv_a[d]), 0);
      chk("rst_flush_d", rda[d], 0);
      chk("rst_flush_d2", rdb[d], 0);
    end
    nx();
    chk("rst_no_late_v", DW'(rdv_a[1]), 0);
    rd_a(8'h10);
    nx();
    chk("rst_mem_kept", rda[0], 32'hDEADBEEF);
    nx(); nx();

    // Back-to-back reads with a clken stall (latency-2 instance).
    nxt = 0;
    prev_en = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (prev_en && rdv_a[1]) got.push_back(rda[1]);
      if (c == 4) begin
        chk("stall_hold_v", DW'(rdv_a[1]), 1);
        chk("stall_hold_d", rda[1], init_word(1));
      end
      idle();
      if (c == 3) clken = 1'b0;
      else if (nxt < 8) begin
        rd_a(AW'(nxt));
        nxt++;
      end
      prev_en = (c != 3);
    end
    chk("stream_count", DW'(got.size()), 8);
    for (int i = 0; i < 8 && i < got.size(); i++)
      chk($sformatf("stream_%0d", i), got[i], init_word(i));

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      nx();
      chipselect    = ($urandom_range(0, 3) != 0);
      write         = 1'($urandom_range(0, 1));
      clken         = ($urandom_range(0, 7) != 0);
      address       = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      byteenable    = BE'($urandom);
      writedata     = $urandom;
      chipselect2   = ($urandom_range(0, 3) != 0);
      write2        = 1'($urandom_range(0, 1));
      clken2        = ($urandom_range(0, 7) != 0);
      address2      = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      byteenable2   = BE'($urandom);
      writedata2    = $urandom;
      reset_req     = ($urandom_range(0, 15) == 0);
      collision_clr = ($urandom_range(0, 7) == 0);
      reset         = ($urandom_range(0, 199) == 0);
    end
    nx(); nx(); nx();
    @(negedge clk);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
